divisor_binario_sequencial: RTL and testbench



---
 rtl/divisor_pkg.sv | 14 +
 rtl/divisor_passo.sv | 34 +++
 rtl/divisor_binario_sequencial.sv | 114 +++++++++++
 tb/tb_divisor_binario_sequencial.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// divisor_pkg: shared types and constants for the sequential restoring divider.
//   estado_t      - controller states (OCIOSO idle, CALCULA iterating, FIM done)
//   DEFAULT_WIDTH - default operand/result width
package divisor_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/divisor_passo.sv
// divisor_passo: one combinational restoring-division step.
//   a      in  WIDTH+1  partial remainder
//   b      in  WIDTH    dividend/quotient shift register
//   d      in  WIDTH    divisor
//   a_next out WIDTH+1  updated partial remainder
//   b_next out WIDTH    shifted register with the new quotient bit in [0]
module divisor_passo #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] b_next
);

  logic [WIDTH:0] a_sh;
  logic           ge;

  assign a_sh = {a[WIDTH-1:0], b[WIDTH-1]};
  // a stays below d, so a[WIDTH] is always 0 in operation; folding it in
  // keeps the compare correct even for an out-of-range remainder.
  assign ge   = a[WIDTH] | (a_sh >= {1'b0, d});

  always_comb begin
    a_next = a_sh;
    b_next = {b[WIDTH-2:0], 1'b0};
    if (ge) begin
      a_next    = a_sh - {1'b0, d};
      b_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/divisor_binario_sequencial.sv
// divisor_binario_sequencial: sequential restoring unsigned divider,
// one quotient bit per clock, WIDTH iterations per operation.
//   clock, reset_n     clock / async active-low reset
//   start              begin division (taken in OCIOSO or in the FIM cycle)
//   dividendo, divisor operands, sampled on the start edge
//   quociente, resto   registered results, held until the next completion
//   pronto             one-cycle completion pulse (state FIM)
//   ocupado            high while iterating (state CALCULA)
//   erro_div_zero      with pronto when the divisor was zero
// Optional macro DIVISOR_ZERO_CHECK_EN: a zero divisor skips the iterations
// and completes in the cycle after start with erro_div_zero set.
module divisor_binario_sequencial
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             pronto,
  output logic             ocupado,
  output logic             erro_div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  estado_t          estado_atual, estado_prox;
  logic [WIDTH:0]   registrador_a, a_passo;
  logic [WIDTH-1:0] registrador_b, registrador_d, b_passo;
  logic [CW-1:0]    contador;
  logic             aceita, div_zero, ultimo;

`ifdef DIVISOR_ZERO_CHECK_EN
  assign div_zero = (divisor == '0);
`else
  assign div_zero = 1'b0;
`endif

  // FIM is the last cycle of an operation, so a start seen there is the
  // back-to-back case and is accepted just like in OCIOSO.
  assign aceita  = start && (estado_atual == OCIOSO || estado_atual == FIM);
  assign ultimo  = (contador == CW'(WIDTH - 1));
  assign pronto  = (estado_atual == FIM);
  assign ocupado = (estado_atual == CALCULA);

  divisor_passo #(.WIDTH(WIDTH)) u_passo (
    .a      (registrador_a),
    .b      (registrador_b),
    .d      (registrador_d),
    .a_next (a_passo),
    .b_next (b_passo)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado_atual <= OCIOSO;
    else          estado_atual <= estado_prox;
  end

  always_comb begin
    estado_prox = estado_atual;
    unique case (estado_atual)
      OCIOSO:  if (start) estado_prox = div_zero ? FIM : CALCULA;
      CALCULA: if (ultimo) estado_prox = FIM;
      FIM:     if (start) estado_prox = div_zero ? FIM : CALCULA;
               else       estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      registrador_a <= '0;
      registrador_b <= '0;
      registrador_d <= '0;
      contador      <= '0;
      quociente     <= '0;
      resto         <= '0;
    end else if (aceita) begin
      registrador_a <= '0;
      registrador_b <= dividendo;
      registrador_d <= divisor;
      contador      <= '0;
      if (div_zero) begin
        quociente <= '1;
        resto     <= dividendo;
      end
    end else if (estado_atual == CALCULA) begin
      registrador_a <= a_passo;
      registrador_b <= b_passo;
      contador      <= contador + CW'(1);
      if (ultimo) begin
        quociente <= b_passo;
        resto     <= a_passo[WIDTH-1:0];
      end
    end
  end

`ifdef DIVISOR_ZERO_CHECK_EN
  logic erro_q;
  // Set only on the edge entering FIM via the zero path; any other edge clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) erro_q <= 1'b0;
    else          erro_q <= aceita && div_zero;
  end
  assign erro_div_zero = erro_q;
`else
  assign erro_div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_binario_sequencial.sv
module tb_divisor_binario_sequencial;
  import divisor_pkg::*;

  localparam int W = 8;
`ifdef DIVISOR_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividendo = '0, divisor = '0;
  logic [W-1:0] quociente, resto;
  logic         pronto, ocupado, erro_div_zero;

  divisor_binario_sequencial #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .dividendo(dividendo), .divisor(divisor),
    .quociente(quociente), .resto(resto),
    .pronto(pronto), .ocupado(ocupado), .erro_div_zero(erro_div_zero)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  int cyc = 0, t0 = 0, p1 = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Operation accepted at edge k completes at edge k+W (k on the zero path);
  // the next start is accepted from one edge after completion.
  int           ec, next_acc, pr_edge;
  logic         pend, m_pronto, m_ocup, m_err;
  logic [W-1:0] pq, pr, m_q, m_r;
  logic         acc, zacc, fin;

  assign acc  = start && (ec >= next_acc);
  assign zacc = acc && ZCHK && (divisor == 0);
  assign fin  = pend && (ec == pr_edge);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ec <= 0; next_acc <= 0; pr_edge <= 0; pend <= 1'b0;
      pq <= '0; pr <= '0; m_q <= '0; m_r <= '0;
      m_pronto <= 1'b0; m_ocup <= 1'b0; m_err <= 1'b0;
    end else begin
      ec       <= ec + 1;
      m_pronto <= zacc || fin;
      m_err    <= zacc;
      m_ocup   <= acc ? !zacc : (pend && !fin);
      if (zacc) begin
        m_q <= 8'hFF; m_r <= dividendo;
      end else if (fin) begin
        m_q <= pq; m_r <= pr;
      end
      if (acc) begin
        pend     <= !zacc;
        pq       <= (divisor == 0) ? 8'hFF : dividendo / divisor;
        pr       <= (divisor == 0) ? dividendo : dividendo % divisor;
        pr_edge  <= ec + W;
        next_acc <= zacc ? ec + 1 : ec + W + 1;
      end else if (fin) begin
        pend <= 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("cmp_pronto", pronto, m_pronto);
      chk("cmp_ocupado", ocupado, m_ocup);
      chk("cmp_quociente", quociente, m_q);
      chk("cmp_resto", resto, m_r);
      chk("cmp_erro", erro_div_zero, m_err);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    dividendo = a; divisor = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string nm, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input int elat, input bit eerr);
    while (!pronto && (cyc - t0) < 40) @(negedge clock);
    if (!pronto) chk({nm, "_timeout"}, 0, 1);
    else begin
      chk({nm, "_lat"}, cyc - t0, elat);
      chk({nm, "_q"}, quociente, eq);
      chk({nm, "_r"}, resto, er);
      chk({nm, "_err"}, erro_div_zero, eerr);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_q", quociente, 0);
    chk("rst_r", resto, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_erro", erro_div_zero, 0);
    chk("rst_estado", int'(dut.estado_atual), int'(OCIOSO));
    reset_n = 1'b1;

    go(8'd120, 8'd96);  wait_done("d120_96", 8'd1, 8'd24, 8, 1'b0);
    go(8'd255, 8'd1);   wait_done("d255_1", 8'd255, 8'd0, 8, 1'b0);
    go(8'd7, 8'd200);
    chk("hold_ocupado", ocupado, 1);
    chk("hold_q", quociente, 255);
    wait_done("d7_200", 8'd0, 8'd7, 8, 1'b0);

    go(8'h50, 8'd0);
    wait_done("dzero", 8'hFF, 8'h50, ZCHK ? 0 : 8, ZCHK);

    // a second start 3 cycles into the operation must be ignored
    go(8'd200, 8'd7);
    repeat (2) @(negedge clock);
    dividendo = 8'd9; divisor = 8'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("d200_7_ign", 8'd28, 8'd4, 8, 1'b0);

    // asynchronous reset in the middle of CALCULA
    go(8'd50, 8'd3);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_q", quociente, 0);
    chk("arst_r", resto, 0);
    chk("arst_pronto", pronto, 0);
    chk("arst_ocupado", ocupado, 0);
    chk("arst_estado", int'(dut.estado_atual), int'(OCIOSO));
    @(negedge clock);
    reset_n = 1'b1;
    go(8'd100, 8'd9);   wait_done("d100_9", 8'd11, 8'd1, 8, 1'b0);

    // back-to-back: start held high through FIM
    @(negedge clock);
    dividendo = 8'd50; divisor = 8'd7; start = 1'b1;
    @(negedge clock);
    t0 = cyc;
    wait_done("b2b_1", 8'd7, 8'd1, 8, 1'b0);
    p1 = cyc;
    dividendo = 8'd99; divisor = 8'd10;
    @(negedge clock);
    start = 1'b0;
    t0 = p1;
    wait_done("b2b_2", 8'd9, 8'd9, 9, 1'b0);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
